laplacian_kxk: RTL and testbench
================================

# laplacian_kxk

Parametrised Laplacian edge-response engine for the event pipeline. It consumes K×K event windows from the event scheduler and emits one signed Laplacian event per window, with the window address carried through. It is the generalised successor to the fixed 5×5 Laplacian stage and adds:

- configurable kernel size;
- a runtime-selectable cross or full neighbourhood;
- magnitude-threshold suppression;
- full downstream backpressure;
- event statistics counters.

## Interface
- K, 5, kernel side; odd, 3..7
- DATA_WIDTH, 4, unsigned window element width
- OUT_WIDTH, DATA_WIDTH+$clog2(K*K)+1, signed output width (derived, not overridden)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_window_value  in  K*K*DATA_WIDTH  element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
- in_window_addr  in  16  window centre address, carried through unchanged
- in_window_valid  in  1  window present
- window_req  out  1  block accepts a window this cycle
- cfg_mode  in  1  0 = cross neighbourhood, 1 = full K×K neighbourhood
- cfg_threshold  in  OUT_WIDTH-1  minimum |result| to emit; 0 passes all
- out_event_value  out  OUT_WIDTH  signed Laplacian result (two's complement)
- out_event_addr  out  16  address of the emitted window
- out_event_valid  out  1  output event present
- ready_for_new_event  in  1  downstream accepts the output event
- stat_emitted  out  16  emitted-event count, saturating
- stat_dropped  out  16  threshold-suppressed count, saturating

## Operation
- Centre element C is at r = c = (K-1)/2.
- Mode 0 (cross): S = sum of centre row and centre column excluding C; N = 2(K-1).
- Mode 1 (full): S = sum of all elements except C; N = K*K-1.
- Result = N*C - S, computed at full precision in OUT_WIDTH; no overflow is possible by construction.
- Accept: a window is accepted when window_req && in_window_valid.
  - cfg_mode and cfg_threshold are sampled at acceptance and travel with the window.
  - A mid-flight configuration change never affects windows already accepted.
- Three pipeline stages:
  - S1: register the window, address and config.
  - S2: C*N and row partial sums of the neighbourhood.
  - S3: subtract, magnitude compare, output register.
- Suppression:
  - If |result| < threshold, no output is produced (a bubble) and stat_dropped increments.
  - Otherwise the output register loads the event, out_event_valid = 1, and stat_emitted increments when the event is loaded.
- Counters stick at 16'hFFFF.

## Timing
- Reset values:
  - window_req = 0 during reset, then 1 from the first cycle after reset is released.
  - out_event_valid = 0, out_event_value = 0, out_event_addr = 0.
  - Both stat counters = 0.
  - All internal valid bits are cleared.
- stall = out_event_valid && !ready_for_new_event.
- window_req = !stall && rst_n.
- S1, S2 and S3 advance only when !stall. The whole pipeline freezes together; no element is lost or duplicated.
- Latency: a window accepted at edge t appears with out_event_valid high after edge t+3 when there are no stalls.
- Throughput: 1 window per cycle.
- Output handshake:
  - Transfer occurs on a cycle with out_event_valid && ready_for_new_event.
  - out_event_value and out_event_addr stay stable while valid && !ready.
  - out_event_valid drops after a transfer unless a new event loads in the same cycle (back-to-back allowed).
- A window that fails the threshold never raises out_event_valid and never causes a stall.
- Simultaneous output transfer and new load in the same cycle: the new event replaces the old one, with no gap cycle.
- in_window_valid while window_req = 0: the window is not accepted, and the upstream holds it.
- Reset mid-operation: in-flight windows are discarded and no output is produced for them. Counters clear.
- Incrementing a counter already at 16'hFFFF leaves it at 16'hFFFF.

## Test plan
- K=5, DW=4, mode 1, threshold 0. Window: C=15, others 0, addr 16'h1234 -> after 3 cycles out_event_value=360, out_event_addr=16'h1234, stat_emitted=1.
- Same window in mode 0 -> 120. Window with C=0, others 15, mode 1 -> -360 (10'h298).
- Uniform window of 7s, threshold 1 -> no out_event_valid within 10 cycles, stat_dropped=1. Same window with threshold 0 -> value 0 emitted.
- Backpressure: stream 8 distinct windows back-to-back while ready_for_new_event toggles 1,0,0,1... -> all 8 events emitted in order, values unchanged while stalled, window_req low exactly on stall cycles.
- Config change: flip cfg_mode on the cycle after accepting window A -> A is computed with the old mode and the next window with the new mode.
- Reset asserted with 3 windows in flight -> no output after reset, counters 0. Force stat_emitted to 16'hFFFF, emit one more event -> it remains 16'hFFFF.

Source files
------------

// File: rtl/laplacian_kxk.sv
// laplacian_kxk: K x K Laplacian edge-response engine. Each accepted window
// yields N*C - S, where S sums either the centre cross or the full
// neighbourhood. Results whose magnitude falls below the threshold are
// suppressed. The whole pipeline freezes while the output event is
// back-pressured, and saturating counters track emitted and suppressed events.
module laplacian_kxk #(
  parameter  int K          = 5,
  parameter  int DATA_WIDTH = 4,
  localparam int OUT_WIDTH  = DATA_WIDTH + $clog2(K*K) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [K*K*DATA_WIDTH-1:0] in_window_value,
  input  logic [15:0]               in_window_addr,
  input  logic                      in_window_valid,
  output logic                      window_req,
  input  logic                      cfg_mode,
  input  logic [OUT_WIDTH-2:0]      cfg_threshold,
  output logic [OUT_WIDTH-1:0]      out_event_value,
  output logic [15:0]               out_event_addr,
  output logic                      out_event_valid,
  input  logic                      ready_for_new_event,
  output logic [15:0]               stat_emitted,
  output logic [15:0]               stat_dropped
);
  localparam int CTR     = (K - 1) / 2;
  localparam int N_CROSS = 2 * (K - 1);
  localparam int N_FULL  = K * K - 1;

  logic stall;
  logic accept;

  // S1 state: the raw window together with the configuration sampled at acceptance
  logic                      s1_valid_reg;
  logic [K*K*DATA_WIDTH-1:0] s1_window_reg;
  logic [15:0]               s1_addr_reg;
  logic                      s1_mode_reg;
  logic [OUT_WIDTH-2:0]      s1_thr_reg;

  // S2 state: weighted centre and per-row neighbourhood sums
  logic                      s2_valid_reg;
  logic [OUT_WIDTH-1:0]      s2_cn_reg;
  logic [OUT_WIDTH-1:0]      s2_row_reg [K];
  logic [15:0]               s2_addr_reg;
  logic [OUT_WIDTH-2:0]      s2_thr_reg;

  // S3 state: final result and its suppression decision
  logic                      s3_valid_reg;
  logic                      s3_pass_reg;
  logic [OUT_WIDTH-1:0]      s3_value_reg;
  logic [15:0]               s3_addr_reg;

  // Output event register and statistics counters
  logic                      out_valid_reg;
  logic [OUT_WIDTH-1:0]      out_value_reg;
  logic [15:0]               out_addr_reg;
  logic [15:0]               emitted_reg;
  logic [15:0]               dropped_reg;

  logic [DATA_WIDTH-1:0]     centre;
  logic [OUT_WIDTH-1:0]      cn_next;
  logic [OUT_WIDTH-1:0]      row_sum [K];
  logic [OUT_WIDTH-1:0]      total;
  logic [OUT_WIDTH-1:0]      result;
  logic [OUT_WIDTH-1:0]      magnitude;

  assign stall      = out_valid_reg && !ready_for_new_event;
  assign window_req = !stall && rst_n;
  assign accept     = window_req && in_window_valid;

  // Capture the accepted window; config travels with it so later changes cannot touch it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_window_reg <= '0;
      s1_addr_reg   <= '0;
      s1_mode_reg   <= 1'b0;
      s1_thr_reg    <= '0;
    end else if (!stall) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_window_reg <= in_window_value;
        s1_addr_reg   <= in_window_addr;
        s1_mode_reg   <= cfg_mode;
        s1_thr_reg    <= cfg_threshold;
      end
    end
  end

  assign centre  = s1_window_reg[(CTR*K+CTR)*DATA_WIDTH +: DATA_WIDTH];
  assign cn_next = OUT_WIDTH'(centre) *
                   (s1_mode_reg ? OUT_WIDTH'(N_FULL) : OUT_WIDTH'(N_CROSS));

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    logic [OUT_WIDTH-1:0] acc;
    // Sum the selected neighbours of this row, never including the centre
    always_comb begin
      acc = '0;
      for (int c = 0; c < K; c++) begin
        if (!(gi == CTR && c == CTR) && (s1_mode_reg || gi == CTR || c == CTR))
          acc = acc + OUT_WIDTH'(s1_window_reg[(gi*K+c)*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
    assign row_sum[gi] = acc;
  end

  // Register the weighted centre and the row partial sums
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_cn_reg    <= '0;
      s2_addr_reg  <= '0;
      s2_thr_reg   <= '0;
      for (int r = 0; r < K; r++) s2_row_reg[r] <= '0;
    end else if (!stall) begin
      s2_valid_reg <= s1_valid_reg;
      s2_cn_reg    <= cn_next;
      s2_addr_reg  <= s1_addr_reg;
      s2_thr_reg   <= s1_thr_reg;
      for (int r = 0; r < K; r++) s2_row_reg[r] <= row_sum[r];
    end
  end

  // Combine row sums, subtract from the weighted centre and take the magnitude
  always_comb begin
    total = '0;
    for (int r = 0; r < K; r++) total = total + s2_row_reg[r];
    result    = s2_cn_reg - total;
    magnitude = result[OUT_WIDTH-1] ? -result : result;
  end

  // Register the result along with whether it clears the threshold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid_reg <= 1'b0;
      s3_pass_reg  <= 1'b0;
      s3_value_reg <= '0;
      s3_addr_reg  <= '0;
    end else if (!stall) begin
      s3_valid_reg <= s2_valid_reg;
      s3_pass_reg  <= magnitude >= {1'b0, s2_thr_reg};
      s3_value_reg <= result;
      s3_addr_reg  <= s2_addr_reg;
    end
  end

  // Load passing events into the output register; suppressed ones leave a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_value_reg <= '0;
      out_addr_reg  <= '0;
      emitted_reg   <= '0;
      dropped_reg   <= '0;
    end else if (!stall) begin
      out_valid_reg <= s3_valid_reg && s3_pass_reg;
      if (s3_valid_reg && s3_pass_reg) begin
        out_value_reg <= s3_value_reg;
        out_addr_reg  <= s3_addr_reg;
        if (emitted_reg != 16'hFFFF) emitted_reg <= emitted_reg + 16'd1;
      end
      if (s3_valid_reg && !s3_pass_reg && dropped_reg != 16'hFFFF)
        dropped_reg <= dropped_reg + 16'd1;
    end
  end

  assign out_event_valid = out_valid_reg;
  assign out_event_value = out_value_reg;
  assign out_event_addr  = out_addr_reg;
  assign stat_emitted    = emitted_reg;
  assign stat_dropped    = dropped_reg;

endmodule

// File: tb/tb_laplacian_kxk.sv
// tb_laplacian_kxk: scoreboard bench for laplacian_kxk (K=5, DATA_WIDTH=4).
// Expected events are queued when a window is accepted and compared when the
// DUT hands an event over downstream.
module tb_laplacian_kxk;
  localparam int K   = 5;
  localparam int DW  = 4;
  localparam int OW  = 10;
  localparam int NW  = K * K * DW;
  localparam int CT  = (K - 1) / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NW-1:0] in_window_value = '0;
  logic [15:0]   in_window_addr = '0;
  logic          in_window_valid = 1'b0;
  logic          window_req;
  logic          cfg_mode = 1'b0;
  logic [OW-2:0] cfg_threshold = '0;
  logic [OW-1:0] out_event_value;
  logic [15:0]   out_event_addr;
  logic          out_event_valid;
  logic          ready_for_new_event = 1'b1;
  logic [15:0]   stat_emitted;
  logic [15:0]   stat_dropped;

  laplacian_kxk #(.K(K), .DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_window_value     (in_window_value),
    .in_window_addr      (in_window_addr),
    .in_window_valid     (in_window_valid),
    .window_req          (window_req),
    .cfg_mode            (cfg_mode),
    .cfg_threshold       (cfg_threshold),
    .out_event_value     (out_event_value),
    .out_event_addr      (out_event_addr),
    .out_event_valid     (out_event_valid),
    .ready_for_new_event (ready_for_new_event),
    .stat_emitted        (stat_emitted),
    .stat_dropped        (stat_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          value;
    logic [15:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_emitted = 0;
  int   exp_dropped = 0;
  int   rdy_pattern = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference Laplacian computed element by element from the window
  function automatic int lap_model(input logic [NW-1:0] w, input logic mode);
    int s;
    int c;
    logic [DW-1:0] e;
    s = 0;
    e = w[(CT*K+CT)*DW +: DW];
    c = int'(e);
    for (int r = 0; r < K; r++)
      for (int q = 0; q < K; q++) begin
        e = w[(r*K+q)*DW +: DW];
        if (!(r == CT && q == CT) && (mode || r == CT || q == CT)) s += int'(e);
      end
    return (mode ? (K*K-1) : 2*(K-1)) * c - s;
  endfunction

  function automatic logic [NW-1:0] make_win(input int centre, input int others);
    logic [NW-1:0] w;
    for (int i = 0; i < K*K; i++) w[i*DW +: DW] = DW'(others);
    w[(CT*K+CT)*DW +: DW] = DW'(centre);
    return w;
  endfunction

  // Ready driver: constant high, or the repeating 1,0,0 pattern
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      ready_for_new_event = (rdy_pattern == 0) ? 1'b1 : (cyc % 3 == 0);
      cyc++;
    end
  end

  // Output monitor: handshake, stability while stalled, scoreboard compare
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_value = '0;
  logic [15:0]   prev_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    logic stall_now;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      stall_now = out_event_valid && !ready_for_new_event;
      check_val("window_req", 32'(window_req), 32'(!stall_now));
      if (prev_stall) begin
        check_val("stall_valid", 32'(out_event_valid), 32'd1);
        check_val("stall_value", 32'(out_event_value), 32'(prev_value));
        check_val("stall_addr", 32'(out_event_addr), 32'(prev_addr));
      end
      if (out_event_valid && ready_for_new_event) begin
        if (sb.size() == 0) begin
          check_val("unexpected_event", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("event addr=%h value=%0d expected=%0d", out_event_addr,
                   $signed(out_event_value), e.value);
          check_val("event_value", 32'($signed(out_event_value)), 32'(e.value));
          check_val("event_addr", 32'(out_event_addr), 32'(e.addr));
        end
      end
      prev_stall = stall_now;
      prev_value = out_event_value;
      prev_addr  = out_event_addr;
    end
  end

  // Present one window, wait (bounded) for acceptance, and book its expected outcome
  task automatic send(input logic [NW-1:0] w, input logic [15:0] a, input logic mode,
                      input int thr, input int exp_val);
    bit ok;
    int mag;
    exp_t e;
    ok = 1'b0;
    in_window_value = w;
    in_window_addr  = a;
    cfg_mode        = mode;
    cfg_threshold   = (OW-1)'(thr);
    in_window_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (window_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("accept_timeout", 32'd0, 32'd1);
    end else begin
      mag = (exp_val < 0) ? -exp_val : exp_val;
      if (mag >= thr) begin
        e.value = exp_val;
        e.addr  = a;
        sb.push_back(e);
        exp_emitted++;
      end else begin
        exp_dropped++;
      end
    end
    @(posedge clk);
    #1;
    in_window_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    check_val("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NW-1:0] w;
    int seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_window_req", 32'(window_req), 32'd0);
    check_val("rst_out_valid", 32'(out_event_valid), 32'd0);
    check_val("rst_out_value", 32'(out_event_value), 32'd0);
    check_val("rst_out_addr", 32'(out_event_addr), 32'd0);
    check_val("rst_emitted", 32'(stat_emitted), 32'd0);
    check_val("rst_dropped", 32'(stat_dropped), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_window_req", 32'(window_req), 32'd1);
    @(posedge clk);
    #1;

    // Centre 15 full mode, with latency check
    send(make_win(15, 0), 16'h1234, 1'b1, 0, 360);
    check_val("lat_t0", 32'(out_event_valid), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("lat_t2", 32'(out_event_valid), 32'd0);
    @(posedge clk); #1;
    check_val("lat_t3", 32'(out_event_valid), 32'd1);
    drain();
    check_val("emitted_after_first", 32'(stat_emitted), 32'd1);

    // Cross mode and negative result
    send(make_win(15, 0), 16'h0101, 1'b0, 0, 120);
    send(make_win(0, 15), 16'h0202, 1'b1, 0, -360);
    drain();

    // Uniform window: suppressed at threshold 1, emitted as 0 at threshold 0
    send(make_win(7, 7), 16'h0303, 1'b1, 1, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_event_valid) seen++;
    end
    check_val("suppressed_no_event", 32'(seen), 32'd0);
    check_val("dropped_count", 32'(stat_dropped), 32'(exp_dropped));
    @(posedge clk); #1;
    send(make_win(7, 7), 16'h0404, 1'b1, 0, 0);
    drain();

    // Back-to-back stream of 8 random windows under 1,0,0 backpressure
    rdy_pattern = 1;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < K*K; i++) w[i*DW +: DW] = DW'($urandom_range(0, 15));
      send(w, 16'(16'h1000 + n), 1'(n % 2), 0, lap_model(w, 1'(n % 2)));
    end
    drain();
    rdy_pattern = 0;
    @(posedge clk); #1;

    // Config flips the cycle after window A is accepted
    w = make_win(9, 3);
    send(w, 16'h0A0A, 1'b0, 0, 9 * 8 - 3 * 8);
    send(w, 16'h0B0B, 1'b1, 0, 9 * 24 - 3 * 24);
    drain();
    check_val("emitted_total", 32'(stat_emitted), 32'(exp_emitted));
    check_val("dropped_total", 32'(stat_dropped), 32'(exp_dropped));

    // Reset with three windows in flight
    send(make_win(15, 0), 16'h0C01, 1'b1, 0, 360);
    send(make_win(15, 0), 16'h0C02, 1'b1, 0, 360);
    send(make_win(15, 0), 16'h0C03, 1'b1, 0, 360);
    rst_n = 1'b0;
    sb.delete();
    exp_emitted = 0;
    exp_dropped = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_event_valid) seen++;
    end
    check_val("flush_no_event", 32'(seen), 32'd0);
    check_val("flush_emitted", 32'(stat_emitted), 32'd0);
    check_val("flush_dropped", 32'(stat_dropped), 32'd0);
    @(posedge clk); #1;

    // Emitted counter saturation
    force dut.emitted_reg = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.emitted_reg;
    check_val("sat_preload", 32'(stat_emitted), 32'h0000FFFF);
    send(make_win(15, 0), 16'h0D0D, 1'b1, 0, 360);
    drain();
    check_val("sat_emitted", 32'(stat_emitted), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
